// File: rtl/mod_n_cascade_counter_if.sv
// Control and status bundle for the cascaded modulo counter.
interface mod_n_cascade_counter_if #(
  parameter int DIGITS  = 2,
  parameter int DIGIT_W = 4
);
  logic                        en;
  logic                        up;
  logic                        load;
  logic [DIGITS*DIGIT_W-1:0]   load_val;
  logic                        sat_mode;
  logic [DIGITS*DIGIT_W-1:0]   count;
  logic                        tc;
  logic                        wrap;
  logic                        sat;

  modport master (
    output en, up, load, load_val, sat_mode,
    input  count, tc, wrap, sat
  );

  modport slave (
    input  en, up, load, load_val, sat_mode,
    output count, tc, wrap, sat
  );
endinterface

// File: rtl/mod_n_cascade_counter.sv
// Synchronous multi-digit modulo-RADIX counter with up/down, load,
// enable, wrap/saturate and cascade terminal count.

// One digit: holds its value and steps modulo RADIX when told to.
module mod_n_digit #(
  parameter int RADIX   = 10,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               up,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_edge
);
  localparam logic [DIGIT_W-1:0] MAXD = DIGIT_W'(RADIX - 1);
  // One extra bit so RADIX == 2**DIGIT_W is representable.
  localparam logic [DIGIT_W:0]   RAD  = (DIGIT_W + 1)'(RADIX);

  logic               valid;
  logic [DIGIT_W-1:0] nxt;

  assign valid   = {1'b0, load_digit} < RAD;
  // Digit sits where a step in the current direction would roll it over.
  assign at_edge = up ? (digit == MAXD) : (digit == '0);

  // Next value for one step in the current direction, rolling at the ends.
  always_comb begin
    nxt = digit;
    if (up) nxt = (digit == MAXD) ? '0 : digit + DIGIT_W'(1);
    else    nxt = (digit == '0) ? MAXD : digit - DIGIT_W'(1);
  end

  // Digit register: reset > load (invalid digits become 0) > step.
  always_ff @(posedge clk) begin
    if (reset)     digit <= '0;
    else if (load) digit <= valid ? load_digit : '0;
    else if (step) digit <= nxt;
  end
endmodule

module mod_n_cascade_counter #(
  parameter int DIGITS  = 2,
  parameter int RADIX   = 10,
  parameter int DIGIT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mod_n_cascade_counter_if.slave   bus
);
  logic [DIGITS-1:0][DIGIT_W-1:0] digits;
  logic [DIGITS-1:0]              at_edge;
  // carry[i]: every digit below i is at its roll-over value.
  logic [DIGITS:0]                carry;
  logic                           term;
  logic                           adv;
  logic                           wrap_q;
  logic                           sat_q;

  assign carry[0] = 1'b1;
  assign term     = carry[DIGITS];
  // Saturation freezes the whole counter at the terminal value.
  assign adv      = bus.en & ~(term & bus.sat_mode);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign carry[g+1] = carry[g] & at_edge[g];
    mod_n_digit #(.RADIX(RADIX), .DIGIT_W(DIGIT_W)) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .step       (adv & carry[g]),
      .up         (bus.up),
      .load_digit (bus.load_val[g*DIGIT_W +: DIGIT_W]),
      .digit      (digits[g]),
      .at_edge    (at_edge[g])
    );
  end

  assign bus.count = digits;
  assign bus.tc    = bus.en & term;
  assign bus.wrap  = wrap_q;
  assign bus.sat   = sat_q;

  // Status flags: wrap pulses on roll-over, sat holds while pinned.
  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (bus.en) begin
      wrap_q <= term & ~bus.sat_mode;
      sat_q  <= term &  bus.sat_mode;
    end else begin
      wrap_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Self-checking bench: vector table, hand sequences, random run vs value model.
module tb_mod_n_cascade_counter;
  localparam int D = 2;
  localparam int R = 10;
  localparam int W = 4;
  localparam int N = R ** D;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 0;

  always #5 clk = ~clk;

  mod_n_cascade_counter_if #(.DIGITS(D), .DIGIT_W(W)) bus ();

  mod_n_cascade_counter #(.DIGITS(D), .RADIX(R), .DIGIT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference state: counter value as a plain integer 0..N-1.
  int   m_val;
  logic m_wrap, m_sat;
  logic tc_seen;

  typedef struct {
    logic       r, e, u, l;
    logic [7:0] lv;
    logic       sm;
    logic [7:0] c;
    logic       w, s;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sanitize(input logic [7:0] lv);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) begin
      int d = int'(lv[i*W +: W]);
      if (d >= R) d = 0;
      v = v * R + d;
    end
    return v;
  endfunction

  function automatic logic [7:0] pack(input int v);
    logic [7:0] p = '0;
    for (int i = 0; i < D; i++) begin
      p[i*W +: W] = W'(v % R);
      v = v / R;
    end
    return p;
  endfunction

  task automatic model_edge(input logic r, e, u, l, input logic [7:0] lv, input logic sm);
    bit at_term;
    if (r) begin
      m_val = 0; m_wrap = 0; m_sat = 0;
    end else if (l) begin
      m_val = sanitize(lv); m_wrap = 0; m_sat = 0;
    end else if (e) begin
      at_term = u ? (m_val == N - 1) : (m_val == 0);
      if (at_term && sm) begin
        m_wrap = 0; m_sat = 1;
      end else if (at_term) begin
        m_val = u ? 0 : N - 1; m_wrap = 1; m_sat = 0;
      end else begin
        m_val = u ? m_val + 1 : m_val - 1; m_wrap = 0; m_sat = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Drive one cycle of inputs, check tc before the edge and state after it.
  task automatic step(input logic r, e, u, l, input logic [7:0] lv, input logic sm);
    logic tc_exp;
    reset = r; bus.en = e; bus.up = u; bus.load = l; bus.load_val = lv; bus.sat_mode = sm;
    #1;
    tc_exp = e & (u ? (m_val == N - 1) : (m_val == 0));
    tc_seen = bus.tc;
    if (!r) chk("tc", 32'(bus.tc), 32'(tc_exp));
    @(posedge clk);
    model_edge(r, e, u, l, lv, sm);
    #1;
    chk("count", 32'(bus.count), 32'(pack(m_val)));
    chk("wrap",  32'(bus.wrap),  32'(m_wrap));
    chk("sat",   32'(bus.sat),   32'(m_sat));
  endtask

  // Every digit must stay below RADIX on every cycle once out of reset.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < D; i++) begin
        n_tests++;
        if (int'(bus.count[i*W +: W]) >= R) begin
          n_fail++;
          $display("FAIL digit_range: digit %0d = %0d, required < %0d", i, bus.count[i*W +: W], R);
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{1,0,1,0,8'h00,0, 8'h00,0,0};
    tbl[1]  = '{0,0,1,1,8'h5A,0, 8'h50,0,0};
    tbl[2]  = '{0,1,1,1,8'h37,0, 8'h37,0,0};
    tbl[3]  = '{0,1,1,0,8'h00,0, 8'h38,0,0};
    tbl[4]  = '{0,1,0,0,8'h00,0, 8'h37,0,0};
    tbl[5]  = '{0,1,1,1,8'h99,1, 8'h99,0,0};
    tbl[6]  = '{0,1,1,0,8'h00,1, 8'h99,0,1};
    tbl[7]  = '{0,0,1,0,8'h00,1, 8'h99,0,1};
    tbl[8]  = '{0,1,1,0,8'h00,0, 8'h00,1,0};
    tbl[9]  = '{0,0,1,0,8'h00,0, 8'h00,0,0};
    tbl[10] = '{0,1,0,0,8'h00,0, 8'h99,1,0};
    tbl[11] = '{0,0,0,1,8'hFF,0, 8'h00,0,0};
    tbl[12] = '{0,0,1,1,8'h09,0, 8'h09,0,0};
    tbl[13] = '{0,1,1,0,8'h00,0, 8'h10,0,0};
    tbl[14] = '{1,1,1,1,8'h55,0, 8'h00,0,0};

    m_val = 0; m_wrap = 0; m_sat = 0;
    reset = 1; bus.en = 0; bus.up = 1; bus.load = 0; bus.load_val = '0; bus.sat_mode = 0;
    @(posedge clk); #1;
    started = 1;
    chk("reset_count", 32'(bus.count), 32'h0);
    chk("reset_wrap",  32'(bus.wrap),  32'h0);
    chk("reset_sat",   32'(bus.sat),   32'h0);

    // Table-driven vectors against fixed expectations.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv, tbl[i].sm);
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_wrap", i),  32'(bus.wrap),  32'(tbl[i].w));
      chk($sformatf("tbl%0d_sat", i),   32'(bus.sat),   32'(tbl[i].s));
    end

    // Full up count to 99, wrap to 00.
    step(1,0,1,0,8'h00,0);
    for (int i = 0; i < 99; i++) step(0,1,1,0,8'h00,0);
    chk("up99_count", 32'(bus.count), 32'h99);
    step(0,1,1,0,8'h00,0);
    chk("up99_tc", 32'(tc_seen), 32'h1);
    chk("upwrap_count", 32'(bus.count), 32'h00);
    chk("upwrap_pulse", 32'(bus.wrap), 32'h1);
    step(0,0,1,0,8'h00,0);
    chk("upwrap_clear", 32'(bus.wrap), 32'h0);

    // Down wrap then 10 more.
    step(0,1,0,0,8'h00,0);
    chk("dnwrap_count", 32'(bus.count), 32'h99);
    chk("dnwrap_pulse", 32'(bus.wrap), 32'h1);
    for (int i = 0; i < 10; i++) step(0,1,0,0,8'h00,0);
    chk("dn10_count", 32'(bus.count), 32'h89);

    // Saturate at 99, then leave by changing direction.
    step(0,0,1,1,8'h98,1);
    step(0,1,1,0,8'h00,1);
    chk("sat1_count", 32'(bus.count), 32'h99);
    chk("sat1_sat", 32'(bus.sat), 32'h0);
    step(0,1,1,0,8'h00,1);
    chk("sat2_count", 32'(bus.count), 32'h99);
    chk("sat2_sat", 32'(bus.sat), 32'h1);
    chk("sat2_wrap", 32'(bus.wrap), 32'h0);
    step(0,1,1,0,8'h00,1);
    chk("sat3_count", 32'(bus.count), 32'h99);
    chk("sat3_wrap", 32'(bus.wrap), 32'h0);
    step(0,1,0,0,8'h00,1);
    chk("satdn_count", 32'(bus.count), 32'h98);
    chk("satdn_sat", 32'(bus.sat), 32'h0);

    // Enable toggling from 09.
    step(0,0,1,1,8'h09,0);
    step(0,0,1,0,8'h00,0);
    chk("tog0_count", 32'(bus.count), 32'h09);
    chk("tog0_tc", 32'(tc_seen), 32'h0);
    step(0,1,1,0,8'h00,0);
    chk("tog1_count", 32'(bus.count), 32'h10);
    step(0,0,1,0,8'h00,0);
    chk("tog2_count", 32'(bus.count), 32'h10);
    step(0,1,1,0,8'h00,0);
    chk("tog3_count", 32'(bus.count), 32'h11);
    chk("tog3_tc", 32'(tc_seen), 32'h0);

    // Reset beats load and enable mid-count.
    step(0,0,1,1,8'h47,0);
    step(1,1,1,1,8'h23,0);
    chk("rstmid_count", 32'(bus.count), 32'h00);
    chk("rstmid_wrap", 32'(bus.wrap), 32'h0);
    chk("rstmid_sat", 32'(bus.sat), 32'h0);

    // Random run against the value model.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
